// File: rtl/de_pipe_reg_param.sv
// de_pipe_reg_param
//   Decode-to-execute pipeline register for the branch/jump calculation path.
//   Carries a payload, a control field and a branch tag through DEPTH
//   back-to-back stages with a valid bit per stage. Supports stall (bubble or
//   hold), flush on misprediction, and saturating bubble/flush counters.
//
// Ports:
//   CLK           rising-edge clock
//   NRST          asynchronous active-low reset
//   data_in       payload from D stage            (DATA_W)
//   ctrl_in       control from D stage            (CTRL_W)
//   tag_in        branch tag from D stage         (TAG_W)
//   valid_in      D-stage entry valid
//   stall         stall request
//   fail_predict  misprediction flush
//   cnt_clr       synchronous clear of both counters
//   data_out      last-stage payload
//   ctrl_out      last-stage control (0 when invalid)
//   tag_out       last-stage tag
//   valid_out     last-stage valid
//   bubble_cnt    stall cycles counted            (CNT_W)
//   flush_cnt     flush cycles counted            (CNT_W)
module de_pipe_reg_param #(
  parameter int unsigned DATA_W     = 90,
  parameter int unsigned CTRL_W     = 5,
  parameter int unsigned TAG_W      = 2,
  parameter int unsigned DEPTH      = 1,
  parameter int unsigned STALL_MODE = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              NRST,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              fail_predict,
  input  logic              cnt_clr,
  output logic [DATA_W-1:0] data_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [TAG_W-1:0]  tag_out,
  output logic              valid_out,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  if ((DEPTH < 1) || (DEPTH > 4)) begin : g_bad_depth
    $error("de_pipe_reg_param: DEPTH must be in 1..4");
  end

  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];
  logic [CTRL_W-1:0] ctrl_q  [DEPTH];
  logic [CTRL_W-1:0] ctrl_d  [DEPTH];
  logic [TAG_W-1:0]  tag_q   [DEPTH];
  logic [TAG_W-1:0]  tag_d   [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;
  logic [CNT_W-1:0]  flush_q,  flush_d;

  logic hold;
  logic load_valid;

  // Flush wins over stall, so a flush always advances even in hold mode.
  assign hold       = stall && !fail_predict && (STALL_MODE != 0);
  assign load_valid = valid_in && !stall && !fail_predict;

  always_comb begin
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    if (!hold) begin
      // Stage 0: a bubble or flush still loads data/tag, but kills valid and
      // ctrl so invalid entries never carry control.
      data_d[0]  = data_in;
      tag_d[0]   = tag_in;
      valid_d[0] = load_valid;
      ctrl_d[0]  = load_valid ? ctrl_in : '0;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        data_d[k]  = data_q[k-1];
        tag_d[k]   = tag_q[k-1];
        valid_d[k] = valid_q[k-1] && !fail_predict;
        ctrl_d[k]  = fail_predict ? '0 : ctrl_q[k-1];
      end
    end
  end

  always_comb begin
    bubble_d = bubble_q;
    flush_d  = flush_q;
    if (cnt_clr) begin
      bubble_d = '0;
      flush_d  = '0;
    end else if (fail_predict) begin
      if (flush_q != '1) flush_d = flush_q + 1'b1;
    end else if (stall) begin
      if (bubble_q != '1) bubble_d = bubble_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      data_q   <= '{default: '0};
      ctrl_q   <= '{default: '0};
      tag_q    <= '{default: '0};
      valid_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      tag_q    <= tag_d;
      valid_q  <= valid_d;
      bubble_q <= bubble_d;
      flush_q  <= flush_d;
    end
  end

  assign data_out   = data_q[DEPTH-1];
  assign ctrl_out   = ctrl_q[DEPTH-1];
  assign tag_out    = tag_q[DEPTH-1];
  assign valid_out  = valid_q[DEPTH-1];
  assign bubble_cnt = bubble_q;
  assign flush_cnt  = flush_q;

endmodule

// File: tb/tb_de_pipe_reg_param.sv
// Testbench for de_pipe_reg_param. Three instances share the stimulus:
//   dut0: DEPTH=1 STALL_MODE=0 CNT_W=16
//   dut1: DEPTH=3 STALL_MODE=1 CNT_W=16
//   dut2: DEPTH=2 STALL_MODE=0 CNT_W=4
// A behavioural model per instance pushes expected outputs to a scoreboard
// queue before each edge; each test pops and compares after the edge.
module tb_de_pipe_reg_param;

  logic        CLK = 1'b0;
  logic        NRST;
  logic [89:0] data_in;
  logic [4:0]  ctrl_in;
  logic [1:0]  tag_in;
  logic        valid_in, stall, fail_predict, cnt_clr;

  logic [89:0] d0, d1, d2;
  logic [4:0]  c0, c1, c2;
  logic [1:0]  t0, t1, t2;
  logic        v0, v1, v2;
  logic [15:0] b0, b1, f0, f1;
  logic [3:0]  b2, f2;

  logic [129:0] act [3];
  logic [129:0] sbq [$];
  logic [129:0] exp_v;

  int checks   = 0;
  int failures = 0;

  // Model state, index [instance][stage]
  logic [89:0] md [3][4];
  logic [4:0]  mc [3][4];
  logic [1:0]  mt [3][4];
  logic        mv [3][4];
  logic [15:0] mb [3];
  logic [15:0] mf [3];
  int          dep  [3] = '{1, 3, 2};
  int          mode [3] = '{0, 1, 0};
  logic [15:0] cmax [3] = '{16'hFFFF, 16'hFFFF, 16'h000F};

  always #5 CLK = ~CLK;

  de_pipe_reg_param #(.DATA_W(90), .CTRL_W(5), .TAG_W(2), .DEPTH(1), .STALL_MODE(0), .CNT_W(16)) u_dut0 (
    .CLK(CLK), .NRST(NRST), .data_in(data_in), .ctrl_in(ctrl_in), .tag_in(tag_in),
    .valid_in(valid_in), .stall(stall), .fail_predict(fail_predict), .cnt_clr(cnt_clr),
    .data_out(d0), .ctrl_out(c0), .tag_out(t0), .valid_out(v0), .bubble_cnt(b0), .flush_cnt(f0));

  de_pipe_reg_param #(.DATA_W(90), .CTRL_W(5), .TAG_W(2), .DEPTH(3), .STALL_MODE(1), .CNT_W(16)) u_dut1 (
    .CLK(CLK), .NRST(NRST), .data_in(data_in), .ctrl_in(ctrl_in), .tag_in(tag_in),
    .valid_in(valid_in), .stall(stall), .fail_predict(fail_predict), .cnt_clr(cnt_clr),
    .data_out(d1), .ctrl_out(c1), .tag_out(t1), .valid_out(v1), .bubble_cnt(b1), .flush_cnt(f1));

  de_pipe_reg_param #(.DATA_W(90), .CTRL_W(5), .TAG_W(2), .DEPTH(2), .STALL_MODE(0), .CNT_W(4)) u_dut2 (
    .CLK(CLK), .NRST(NRST), .data_in(data_in), .ctrl_in(ctrl_in), .tag_in(tag_in),
    .valid_in(valid_in), .stall(stall), .fail_predict(fail_predict), .cnt_clr(cnt_clr),
    .data_out(d2), .ctrl_out(c2), .tag_out(t2), .valid_out(v2), .bubble_cnt(b2), .flush_cnt(f2));

  assign act[0] = {v0, c0, t0, d0, b0, f0};
  assign act[1] = {v1, c1, t1, d1, b1, f1};
  assign act[2] = {v2, c2, t2, d2, 12'h000, b2, 12'h000, f2};

  task model_clear();
    for (int u = 0; u < 3; u++) begin
      for (int k = 0; k < 4; k++) begin
        md[u][k] = '0; mc[u][k] = '0; mt[u][k] = '0; mv[u][k] = 1'b0;
      end
      mb[u] = '0;
      mf[u] = '0;
    end
    sbq.delete();
  endtask

  task model_edge(input int u);
    if (fail_predict || !(stall && mode[u] == 1)) begin
      for (int k = dep[u] - 1; k > 0; k--) begin
        md[u][k] = md[u][k-1];
        mt[u][k] = mt[u][k-1];
        mv[u][k] = fail_predict ? 1'b0 : mv[u][k-1];
        mc[u][k] = fail_predict ? 5'h00 : mc[u][k-1];
      end
      md[u][0] = data_in;
      mt[u][0] = tag_in;
      mv[u][0] = (fail_predict || stall) ? 1'b0 : valid_in;
      mc[u][0] = (fail_predict || stall || !valid_in) ? 5'h00 : ctrl_in;
    end
    if (cnt_clr) begin
      mb[u] = '0;
      mf[u] = '0;
    end else if (fail_predict) begin
      if (mf[u] != cmax[u]) mf[u] = mf[u] + 16'd1;
    end else if (stall) begin
      if (mb[u] != cmax[u]) mb[u] = mb[u] + 16'd1;
    end
  endtask

  // Update the model, queue the expected outputs, then advance one edge.
  task advance();
    for (int u = 0; u < 3; u++) begin
      model_edge(u);
      sbq.push_back({mv[u][dep[u]-1], mc[u][dep[u]-1], mt[u][dep[u]-1],
                     md[u][dep[u]-1], mb[u], mf[u]});
    end
    @(posedge CLK);
    #1;
  endtask

  task set_in(input logic [89:0] d, input logic [4:0] c, input logic [1:0] t,
              input logic v, input logic s, input logic f, input logic cl);
    data_in = d; ctrl_in = c; tag_in = t; valid_in = v;
    stall = s; fail_predict = f; cnt_clr = cl;
  endtask

  task test_reset();
    NRST = 1'b0;
    set_in('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_clear();
    #3;
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (act[u] !== 130'd0) begin
        failures++;
        $display("FAIL reset dut%0d got=%h exp=0", u, act[u]);
      end
    end
    @(negedge CLK);
    NRST = 1'b1;
  endtask

  task test_normal();
    set_in(90'h2AA_5555_AAAA_5555_AAAA_5555, 5'h13, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    advance();
    for (int u = 0; u < 3; u++) begin
      exp_v = sbq.pop_front(); checks++;
      if (act[u] !== exp_v) begin failures++; $display("FAIL normal.sb dut%0d got=%h exp=%h", u, act[u], exp_v); end
    end
    checks++;
    if ({v0, c0, t0, d0} !== {1'b1, 5'h13, 2'd2, 90'h2AA_5555_AAAA_5555_AAAA_5555}) begin
      failures++;
      $display("FAIL normal.out got=%b/%h/%h/%h exp=1/13/2/A", v0, c0, t0, d0);
    end
  endtask

  task test_bubble();
    set_in(90'h0BB_0000_1111_2222_3333_4444, 5'h1F, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    advance();
    for (int u = 0; u < 3; u++) begin
      exp_v = sbq.pop_front(); checks++;
      if (act[u] !== exp_v) begin failures++; $display("FAIL bubble.sb dut%0d got=%h exp=%h", u, act[u], exp_v); end
    end
    checks++;
    if ({v0, c0, d0, b0} !== {1'b0, 5'h00, 90'h0BB_0000_1111_2222_3333_4444, 16'd1}) begin
      failures++;
      $display("FAIL bubble.out got v=%b c=%h d=%h b=%0d exp v=0 c=0 d=B b=1", v0, c0, d0, b0);
    end
    stall = 1'b0;
  endtask

  task test_hold();
    logic [89:0] e [3];
    logic [15:0] bstart;
    e[0] = 90'h0E1; e[1] = 90'h0E2; e[2] = 90'h0E3;
    for (int i = 0; i < 3; i++) begin
      set_in(e[i], 5'(i + 1), 2'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      advance();
      for (int u = 0; u < 3; u++) begin
        exp_v = sbq.pop_front(); checks++;
        if (act[u] !== exp_v) begin failures++; $display("FAIL hold.fill dut%0d got=%h exp=%h", u, act[u], exp_v); end
      end
    end
    bstart = mb[1];
    for (int i = 0; i < 4; i++) begin
      set_in(90'h3FF_0000 + 90'(i), 5'h0A, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      advance();
      for (int u = 0; u < 3; u++) begin
        exp_v = sbq.pop_front(); checks++;
        if (act[u] !== exp_v) begin failures++; $display("FAIL hold.stall dut%0d got=%h exp=%h", u, act[u], exp_v); end
      end
      checks++;
      if ({v1, c1, d1} !== {1'b1, 5'd1, e[0]}) begin
        failures++;
        $display("FAIL hold.e1 cyc%0d got v=%b c=%h d=%h exp v=1 c=1 d=%h", i, v1, c1, d1, e[0]);
      end
    end
    checks++;
    if (b1 !== bstart + 16'd4) begin
      failures++;
      $display("FAIL hold.bcnt got=%0d exp=%0d", b1, bstart + 16'd4);
    end
    for (int i = 1; i < 3; i++) begin
      set_in('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      advance();
      for (int u = 0; u < 3; u++) begin
        exp_v = sbq.pop_front(); checks++;
        if (act[u] !== exp_v) begin failures++; $display("FAIL hold.drain dut%0d got=%h exp=%h", u, act[u], exp_v); end
      end
      checks++;
      if ({v1, d1} !== {1'b1, e[i]}) begin
        failures++;
        $display("FAIL hold.release got v=%b d=%h exp v=1 d=%h", v1, d1, e[i]);
      end
    end
  endtask

  task test_flush();
    logic [15:0] fstart, bstart;
    for (int i = 0; i < 3; i++) begin
      set_in(90'h100 + 90'(i), 5'h11, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      advance();
      for (int u = 0; u < 3; u++) begin
        exp_v = sbq.pop_front(); checks++;
        if (act[u] !== exp_v) begin failures++; $display("FAIL flush.fill dut%0d got=%h exp=%h", u, act[u], exp_v); end
      end
    end
    fstart = mf[1];
    bstart = mb[1];
    for (int i = 0; i < 3; i++) begin
      set_in(90'h200 + 90'(i), 5'h1E, 2'd2, 1'b1, (i == 0), (i == 0), 1'b0);
      advance();
      for (int u = 0; u < 3; u++) begin
        exp_v = sbq.pop_front(); checks++;
        if (act[u] !== exp_v) begin failures++; $display("FAIL flush.sb dut%0d got=%h exp=%h", u, act[u], exp_v); end
      end
      checks++;
      if ({v1, c1} !== 6'd0) begin
        failures++;
        $display("FAIL flush.kill cyc%0d got v=%b c=%h exp v=0 c=0", i, v1, c1);
      end
    end
    checks++;
    if ({f1, b1} !== {fstart + 16'd1, bstart}) begin
      failures++;
      $display("FAIL flush.cnt got f=%0d b=%0d exp f=%0d b=%0d", f1, b1, fstart + 16'd1, bstart);
    end
  endtask

  task test_saturate();
    for (int i = 0; i < 20; i++) begin
      set_in(90'(i), 5'h07, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      advance();
      for (int u = 0; u < 3; u++) begin
        exp_v = sbq.pop_front(); checks++;
        if (act[u] !== exp_v) begin failures++; $display("FAIL sat.sb dut%0d got=%h exp=%h", u, act[u], exp_v); end
      end
    end
    checks++;
    if (b2 !== 4'hF) begin failures++; $display("FAIL sat.max got=%h exp=f", b2); end
    set_in('0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    advance();
    for (int u = 0; u < 3; u++) begin
      exp_v = sbq.pop_front(); checks++;
      if (act[u] !== exp_v) begin failures++; $display("FAIL sat.clr dut%0d got=%h exp=%h", u, act[u], exp_v); end
    end
    checks++;
    if ({b2, b0, f1} !== 36'd0) begin
      failures++;
      $display("FAIL sat.clr0 got b2=%h b0=%h f1=%h exp 0", b2, b0, f1);
    end
    cnt_clr = 1'b0;
    stall   = 1'b0;
  endtask

  task test_back_to_back();
    logic [95:0] r;
    for (int i = 0; i < 40; i++) begin
      r = {$urandom, $urandom, $urandom};
      set_in(r[89:0], 5'($urandom), 2'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 15) == 0));
      advance();
      for (int u = 0; u < 3; u++) begin
        exp_v = sbq.pop_front(); checks++;
        if (act[u] !== exp_v) begin failures++; $display("FAIL b2b.sb i%0d dut%0d got=%h exp=%h", i, u, act[u], exp_v); end
      end
    end
  endtask

  task test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      set_in(90'h0C0 + 90'(i), 5'h15, 2'd3, 1'b1, 1'b0, (i == 1), 1'b0);
      advance();
      for (int u = 0; u < 3; u++) begin
        exp_v = sbq.pop_front(); checks++;
        if (act[u] !== exp_v) begin failures++; $display("FAIL rstmid.fill dut%0d got=%h exp=%h", u, act[u], exp_v); end
      end
    end
    set_in(90'h0C9, 5'h15, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    NRST = 1'b0;
    model_clear();
    #1;
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (act[u] !== 130'd0) begin
        failures++;
        $display("FAIL rstmid.async dut%0d got=%h exp=0", u, act[u]);
      end
    end
    @(negedge CLK);
    NRST = 1'b1;
    set_in(90'h0D1, 5'h09, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    advance();
    for (int u = 0; u < 3; u++) begin
      exp_v = sbq.pop_front(); checks++;
      if (act[u] !== exp_v) begin failures++; $display("FAIL rstmid.after dut%0d got=%h exp=%h", u, act[u], exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_bubble();
    test_hold();
    test_flush();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/de_pipe_reg_param.md
Name: de_pipe_reg_param

Overview:
- Parametrised decode-to-execute pipeline register for the branch/jump calculation path.
- Carries a data payload, a control field and a branch tag through DEPTH back-to-back stages, with a valid bit per stage.
- Supports stall in two modes: bubble-insert or hold. Flush on fail_predict, plus saturating bubble/flush event counters.
- Sits between decode and the execute-stage PC calculation unit; DEPTH>1 is used for retiming.

Parameters:
- DATA_W, 90, payload width (pc, reg_data1/2, imm, state packed by the instantiator).
- CTRL_W, 5, control width (jump_code and branch_code); forced to 0 on killed/bubbled entries.
- TAG_W, 2, branch tag width (branch_number).
- DEPTH, 1, number of register stages, legal 1..4.
- STALL_MODE, 0. 0 = stall inserts a bubble while the pipe keeps moving; 1 = stall freezes all stages.
- CNT_W, 16, event counter width.

Ports:
- CLK  input  1  clock, rising edge
- NRST  input  1  asynchronous active-low reset
- data_in  input  DATA_W  payload from D stage
- ctrl_in  input  CTRL_W  control from D stage
- tag_in  input  TAG_W  branch tag from D stage
- valid_in  input  1  D-stage entry valid
- stall  input  1  stall request
- fail_predict  input  1  misprediction flush
- cnt_clr  input  1  synchronous clear of both counters
- data_out  output  DATA_W  last-stage payload
- ctrl_out  output  CTRL_W  last-stage control (0 when invalid)
- tag_out  output  TAG_W  last-stage tag
- valid_out  output  1  last-stage valid
- bubble_cnt  output  CNT_W  stall cycles counted
- flush_cnt  output  CNT_W  flush cycles counted

Behaviour:
- Reset (NRST=0, async): every stage's data, ctrl, tag and valid = 0; both counters = 0. Outputs read 0 immediately. Reset mid-stall or mid-flush discards all state; first edge after release behaves normally.
- Latency: DEPTH cycles from inputs to outputs. Stage k+1 loads stage k each advancing edge; stage 0 loads the inputs.
- Invariant: a stage with valid=0 always holds ctrl=0. Stage 0 loads ctrl=0 when valid_in=0.
- Priority per edge: fail_predict > stall > normal.
- fail_predict=1 (either mode):
  - All stages advance. data and tag shift normally.
  - Every stage, including stage 0's newly loaded entry, gets valid=0 and ctrl=0.
  - Overrides the hold in STALL_MODE=1.
- stall=1, fail_predict=0, STALL_MODE=0:
  - Stage 0 loads data_in/tag_in with valid=0 and ctrl=0 (bubble).
  - Stages 1..DEPTH-1 advance normally.
- stall=1, fail_predict=0, STALL_MODE=1:
  - All stages hold every field.
  - Inputs are ignored; the upstream stage must hold them.
- Normal edge: all stages advance; stage 0 loads valid=valid_in, ctrl=valid_in?ctrl_in:0.
- Counters:
  - bubble_cnt +1 on each edge with stall=1 and fail_predict=0.
  - flush_cnt +1 on each edge with fail_predict=1.
  - Both saturate at all-ones with no wrap.
  - cnt_clr=1 sets both to 0 on that edge, taking priority over increment.
- DEPTH outside 1..4: elaboration error.
- No combinational path from inputs to outputs.

Test Plan:
- DEPTH=1, MODE=0. Reset, then valid_in=1, ctrl_in=5'h13, tag_in=2, data_in=A. One edge later: valid_out=1, ctrl_out=5'h13, tag_out=2, data_out=A.
- DEPTH=1, MODE=0. stall=1 with ctrl_in=5'h1F, data_in=B. Next cycle: valid_out=0, ctrl_out=0, data_out=B, bubble_cnt=1.
- DEPTH=3, MODE=1. Fill with entries E1,E2,E3, then stall 4 cycles. Outputs stay at E1 all 4 cycles and bubble_cnt=4. After release, E2 and E3 emerge on consecutive cycles.
- DEPTH=3, MODE=1. stall=1 and fail_predict=1 together with 3 valid entries in flight. Next 3 cycles: valid_out=0, ctrl_out=0. flush_cnt=1, bubble_cnt unchanged.
- CNT_W=4. Stall for 20 cycles -> bubble_cnt saturates at 4'hF. Then cnt_clr=1 with stall=1 -> bubble_cnt=0.
- Assert NRST low mid-stream with valid entries present. valid_out, ctrl_out, data_out and both counters read 0 before the next CLK edge.
